// File: rtl/effect_param_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : effect_param_ctrl                                         |
// | Purpose  : Host-side parameter staging for a bitcrush + delay effect |
// |            chain. Host writes land in shadow registers; a commit     |
// |            applies them to the live outputs on an audio sample       |
// |            boundary, optionally ramping the feedback/wet amounts.    |
// | Config   : define EFFECT_PARAM_CTRL_RAMP_EN to enable amount ramping |
// |            and click-free delay enable/disable sequencing.           |
// | Ports    : clk, rst (sync, active-high)                              |
// |            wr_valid/wr_ready/wr_addr/wr_data - host write channel    |
// |            commit          - apply staged values                     |
// |            sample_valid    - audio sample strobe (timebase)          |
// |            busy            - commit in progress                      |
// |            enable_bitcrush, enable_delay, bit_depth,                 |
// |            delay_num_samples, delay_feedback_amount,                 |
// |            delay_effect_amount - live effect parameters              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module effect_param_ctrl #(
   parameter int RAMP_STEP     = 4,
   parameter int BIT_DEPTH_RST = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        commit,
   input  logic        sample_valid,
   output logic        busy,
   output logic        enable_bitcrush,
   output logic        enable_delay,
   output logic [4:0]  bit_depth,
   output logic [15:0] delay_num_samples,
   output logic [7:0]  delay_feedback_amount,
   output logic [7:0]  delay_effect_amount
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      RAMP    = 2'd2
   } state_t;

   localparam logic [7:0]  STEP      = 8'(RAMP_STEP);
   localparam logic [4:0]  DEPTH_RST = 5'(BIT_DEPTH_RST);
   localparam logic [15:0] NUM_RST   = 16'd4800;

   // One ramp step toward tgt, clamped so it never overshoots or wraps.
   function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [7:0] diff;
      if (cur < tgt) begin
         diff        = tgt - cur;
         ramp_toward = (diff > STEP) ? cur + STEP : tgt;
      end else begin
         diff        = cur - tgt;
         ramp_toward = (diff > STEP) ? cur - STEP : tgt;
      end
   endfunction

   state_t      state_q, state_d;
   logic        first_q, first_d;        // set during the PENDING entry cycle
   logic        en_bc_q, en_bc_d;
   logic        en_dl_q, en_dl_d;
   logic [4:0]  depth_q, depth_d;
   logic [15:0] num_q, num_d;
   logic [7:0]  fb_q, fb_d;
   logic [7:0]  fx_q, fx_d;
   logic        sh_en_bc_q, sh_en_bc_d;
   logic        sh_en_dl_q, sh_en_dl_d;
   logic [4:0]  sh_depth_q, sh_depth_d;
   logic [15:0] sh_num_q, sh_num_d;
   logic [7:0]  sh_fb_q, sh_fb_d;
   logic [7:0]  sh_fx_q, sh_fx_d;
   logic [7:0]  fb_tgt_q, fb_tgt_d;
   logic [7:0]  fx_tgt_q, fx_tgt_d;
   logic        dis_pend_q, dis_pend_d;  // delay disable waiting for wet amount to reach 0

   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      en_bc_d    = en_bc_q;
      en_dl_d    = en_dl_q;
      depth_d    = depth_q;
      num_d      = num_q;
      fb_d       = fb_q;
      fx_d       = fx_q;
      sh_en_bc_d = sh_en_bc_q;
      sh_en_dl_d = sh_en_dl_q;
      sh_depth_d = sh_depth_q;
      sh_num_d   = sh_num_q;
      sh_fb_d    = sh_fb_q;
      sh_fx_d    = sh_fx_q;
      fb_tgt_d   = fb_tgt_q;
      fx_tgt_d   = fx_tgt_q;
      dis_pend_d = dis_pend_q;

      // Host writes only touch shadows and are only accepted in IDLE.
      if (wr_valid && (state_q == IDLE)) begin
         case (wr_addr)
            3'd0: begin
               sh_en_bc_d = wr_data[0];
               sh_en_dl_d = wr_data[1];
            end
            3'd1: sh_depth_d = (wr_data[4:0] == 5'd0) ? 5'd1 : wr_data[4:0];
            3'd2: sh_num_d   = wr_data;
            3'd3: sh_fb_d    = wr_data[7:0];
            3'd4: sh_fx_d    = wr_data[7:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (commit) begin
               state_d = PENDING;
               first_d = 1'b1;
            end
         end
         PENDING: begin
            first_d = 1'b0;
            if (sample_valid && !first_q) begin
               en_bc_d = sh_en_bc_q;
               depth_d = sh_depth_q;
               num_d   = sh_num_q;
`ifdef EFFECT_PARAM_CTRL_RAMP_EN
               fb_tgt_d = sh_fb_q;
               fx_tgt_d = sh_fx_q;
               if (sh_en_dl_q && !en_dl_q) begin
                  // Turning the delay on: start the wet path silent.
                  en_dl_d = 1'b1;
                  fx_d    = 8'd0;
               end else if (!sh_en_dl_q && en_dl_q) begin
                  // Turning the delay off: fade wet to 0 before dropping enable.
                  fx_tgt_d   = 8'd0;
                  dis_pend_d = 1'b1;
               end
               state_d = RAMP;
`else
               en_dl_d = sh_en_dl_q;
               fb_d    = sh_fb_q;
               fx_d    = sh_fx_q;
               state_d = IDLE;
`endif
            end
         end
         RAMP: begin
            if (sample_valid) begin
               fb_d = ramp_toward(fb_q, fb_tgt_q);
               fx_d = ramp_toward(fx_q, fx_tgt_q);
            end
            if (dis_pend_q && (fx_q == 8'd0)) begin
               en_dl_d    = 1'b0;
               dis_pend_d = 1'b0;
            end
            if ((fb_q == fb_tgt_q) && (fx_q == fx_tgt_q) && !dis_pend_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         first_q    <= 1'b0;
         en_bc_q    <= 1'b0;
         en_dl_q    <= 1'b0;
         depth_q    <= DEPTH_RST;
         num_q      <= NUM_RST;
         fb_q       <= 8'd0;
         fx_q       <= 8'd0;
         sh_en_bc_q <= 1'b0;
         sh_en_dl_q <= 1'b0;
         sh_depth_q <= DEPTH_RST;
         sh_num_q   <= NUM_RST;
         sh_fb_q    <= 8'd0;
         sh_fx_q    <= 8'd0;
         fb_tgt_q   <= 8'd0;
         fx_tgt_q   <= 8'd0;
         dis_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         en_bc_q    <= en_bc_d;
         en_dl_q    <= en_dl_d;
         depth_q    <= depth_d;
         num_q      <= num_d;
         fb_q       <= fb_d;
         fx_q       <= fx_d;
         sh_en_bc_q <= sh_en_bc_d;
         sh_en_dl_q <= sh_en_dl_d;
         sh_depth_q <= sh_depth_d;
         sh_num_q   <= sh_num_d;
         sh_fb_q    <= sh_fb_d;
         sh_fx_q    <= sh_fx_d;
         fb_tgt_q   <= fb_tgt_d;
         fx_tgt_q   <= fx_tgt_d;
         dis_pend_q <= dis_pend_d;
      end
   end

   assign wr_ready              = (state_q == IDLE);
   assign busy                  = (state_q != IDLE);
   assign enable_bitcrush       = en_bc_q;
   assign enable_delay          = en_dl_q;
   assign bit_depth             = depth_q;
   assign delay_num_samples     = num_q;
   assign delay_feedback_amount = fb_q;
   assign delay_effect_amount   = fx_q;

endmodule
`default_nettype wire

// File: tb/tb_effect_param_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_effect_param_ctrl                                      |
// | Purpose  : Directed self-checking bench for effect_param_ctrl.       |
// |            Expected values follow EFFECT_PARAM_CTRL_RAMP_EN when set.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_effect_param_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [2:0]  wr_addr = 3'd0;
   logic [15:0] wr_data = 16'd0;
   logic        commit = 1'b0;
   logic        sample_valid = 1'b0;
   logic        busy;
   logic        enable_bitcrush;
   logic        enable_delay;
   logic [4:0]  bit_depth;
   logic [15:0] delay_num_samples;
   logic [7:0]  delay_feedback_amount;
   logic [7:0]  delay_effect_amount;

   int checks = 0;
   int errors = 0;

   effect_param_ctrl #(
      .RAMP_STEP     (4),
      .BIT_DEPTH_RST (24)
   ) u_dut (
      .clk                   (clk),
      .rst                   (rst),
      .wr_valid              (wr_valid),
      .wr_ready              (wr_ready),
      .wr_addr               (wr_addr),
      .wr_data               (wr_data),
      .commit                (commit),
      .sample_valid          (sample_valid),
      .busy                  (busy),
      .enable_bitcrush       (enable_bitcrush),
      .enable_delay          (enable_delay),
      .bit_depth             (bit_depth),
      .delay_num_samples     (delay_num_samples),
      .delay_feedback_amount (delay_feedback_amount),
      .delay_effect_amount   (delay_effect_amount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic sample();
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   // Commit, then step past the PENDING entry cycle.
   task automatic commit_go();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_en_bc"}, 32'(enable_bitcrush), 32'd0);
      chk({tag, "_en_dl"}, 32'(enable_delay), 32'd0);
      chk({tag, "_depth"}, 32'(bit_depth), 32'd24);
      chk({tag, "_num"},   32'(delay_num_samples), 32'd4800);
      chk({tag, "_fb"},    32'(delay_feedback_amount), 32'd0);
      chk({tag, "_fx"},    32'(delay_effect_amount), 32'd0);
      chk({tag, "_ready"}, 32'(wr_ready), 32'd1);
      chk({tag, "_busy"},  32'(busy), 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk_reset_vals("rst");

      // Write depth with commit in the same cycle; live value waits for a sample
      wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'd8; commit = 1'b1;
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      chk("pend_busy", 32'(busy), 32'd1);
      chk("pend_ready", 32'(wr_ready), 32'd0);
      for (int i = 0; i < 50; i++) tick();
      chk("pend_depth_hold", 32'(bit_depth), 32'd24);
      chk("pend_busy_hold", 32'(busy), 32'd1);
      sample();
      chk("apply_depth", 32'(bit_depth), 32'd8);
      tick();
      chk("apply_done_busy", 32'(busy), 32'd0);

      // Enable delay with effect 10, feedback 7, length 1000
      wr(3'd0, 16'd2);
      wr(3'd4, 16'd10);
      wr(3'd3, 16'd7);
      wr(3'd2, 16'd1000);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      // Write and commit while busy must be ignored
      wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 16'd99; commit = 1'b1;
      chk("busy_ready", 32'(wr_ready), 32'd0);
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      sample();
      chk("on_en_dl", 32'(enable_delay), 32'd1);
      chk("on_num", 32'(delay_num_samples), 32'd1000);
`ifdef EFFECT_PARAM_CTRL_RAMP_EN
      chk("on_fx0", 32'(delay_effect_amount), 32'd0);
      chk("on_fb0", 32'(delay_feedback_amount), 32'd0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("ramp_hold_fx", 32'(delay_effect_amount), 32'd0);
      sample();
      chk("on_fx4", 32'(delay_effect_amount), 32'd4);
      chk("on_fb4", 32'(delay_feedback_amount), 32'd4);
      sample();
      chk("on_fx8", 32'(delay_effect_amount), 32'd8);
      chk("on_fb7", 32'(delay_feedback_amount), 32'd7);
      sample();
      chk("on_fx10", 32'(delay_effect_amount), 32'd10);
      chk("on_busy_end", 32'(busy), 32'd1);
      tick();
      chk("on_idle", 32'(busy), 32'd0);
      tick();
      chk("on_no_queue", 32'(busy), 32'd0);
`else
      chk("on_fx10", 32'(delay_effect_amount), 32'd10);
      chk("on_fb7", 32'(delay_feedback_amount), 32'd7);
      chk("on_idle", 32'(busy), 32'd0);
`endif

      // Disable delay
      wr(3'd0, 16'd0);
      commit_go();
      sample();
`ifdef EFFECT_PARAM_CTRL_RAMP_EN
      chk("off_en_keep", 32'(enable_delay), 32'd1);
      chk("off_fx10", 32'(delay_effect_amount), 32'd10);
      sample();
      chk("off_fx6", 32'(delay_effect_amount), 32'd6);
      sample();
      chk("off_fx2", 32'(delay_effect_amount), 32'd2);
      sample();
      chk("off_fx0", 32'(delay_effect_amount), 32'd0);
      chk("off_en_still", 32'(enable_delay), 32'd1);
      tick();
      chk("off_en_clr", 32'(enable_delay), 32'd0);
      chk("off_busy", 32'(busy), 32'd1);
      tick();
      chk("off_idle", 32'(busy), 32'd0);
`else
      chk("off_en", 32'(enable_delay), 32'd0);
      chk("off_fx", 32'(delay_effect_amount), 32'd10);
      chk("off_idle", 32'(busy), 32'd0);
`endif

      // Reset mid-operation, with write and commit asserted during reset
      wr(3'd0, 16'd2);
      commit_go();
`ifdef EFFECT_PARAM_CTRL_RAMP_EN
      sample();
      sample();
      chk("pre_rst_fx", 32'(delay_effect_amount), 32'd4);
`endif
      rst = 1'b1; wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'd5; commit = 1'b1;
      tick();
      chk_reset_vals("mid_rst");
      rst = 1'b0; wr_valid = 1'b0; commit = 1'b0;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Depth 0 is stored as 1; other shadows must be back at reset values
      wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'd0; commit = 1'b1;
      tick();
      wr_valid = 1'b0; commit = 1'b0;
      tick();
      sample();
      chk("zero_depth", 32'(bit_depth), 32'd1);
      chk("shadow_num_rst", 32'(delay_num_samples), 32'd4800);
      chk("shadow_en_rst", 32'(enable_delay), 32'd0);
      chk("shadow_fx_rst", 32'(delay_effect_amount), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/effect_param_ctrl.md
EFFECT_PARAM_CTRL -- requirements
Module: effect_param_ctrl

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 4, meaning per-sample increment/decrement of feedback/effect amounts (legal 1..255).
REQ-002 SHALL have parameter BIT_DEPTH_RST, default 24, meaning reset value of bit_depth (legal 1..31).
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host parameter-write strobe.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  3  register select.
- wr_data  in  16  write data.
- commit  in  1  one-cycle request to apply staged values.
- sample_valid  in  1  audio sample strobe, the effect-chain timebase.
- busy  out  1  commit in progress.
- enable_bitcrush  out  1  live bitcrush enable.
- enable_delay  out  1  live delay enable.
- bit_depth  out  5  live bitcrush depth.
- delay_num_samples  out  16  live delay length.
- delay_feedback_amount  out  8  live feedback amount.
- delay_effect_amount  out  8  live wet amount.

Function
REQ-004 SHALL hold a shadow register per live output; accepted writes update shadows only, never live outputs.
REQ-005 Address map SHALL be: 0 = enables (bit0 bitcrush, bit1 delay); 1 = bit_depth (data[4:0], 0 stored as 1); 2 = delay_num_samples; 3 = feedback (data[7:0]); 4 = effect (data[7:0]); 5-7 accepted and discarded.
REQ-006 SHALL implement states IDLE, PENDING, RAMP; wr_ready = (state==IDLE); busy = (state!=IDLE).
REQ-007 IDLE: commit=1 -> PENDING next cycle; a write accepted in the same cycle as commit SHALL be included in that commit.
REQ-008 commit while busy SHALL be ignored (no queuing).
REQ-009 PENDING: on the first sample_valid strictly after entry (not in the entry cycle), SHALL copy enable_bitcrush, bit_depth, delay_num_samples from shadows, live values visible the following cycle; then -> RAMP.
REQ-010 At apply, delay enable 0->1 SHALL set enable_delay and force delay_effect_amount to 0 before ramping to the shadow value.
REQ-011 At apply, delay enable 1->0 SHALL keep enable_delay=1 and ramp effect target to 0; enable_delay SHALL clear in the cycle after delay_effect_amount reaches 0.
REQ-012 RAMP: on each sample_valid, feedback and effect SHALL each move toward their target by min(RAMP_STEP, |target-live|), no overshoot, no wrap.
REQ-013 RAMP -> IDLE in the cycle after both amounts equal targets and any pending disable has completed.
REQ-014 Outside apply/RAMP events, live outputs SHALL be constant; sample_valid in IDLE has no effect.

Reset
REQ-015 rst=1 SHALL, in the next cycle and regardless of state (including mid-PENDING/RAMP), force state IDLE, wr_ready=1, busy=0, enables 0, bit_depth=BIT_DEPTH_RST, delay_num_samples=4800, feedback=0, effect=0, shadows equal to these values.
REQ-016 While rst=1, writes and commit SHALL be ignored.

Configuration
REQ-017 With EFFECT_PARAM_CTRL_RAMP_EN defined, REQ-010 to REQ-013 SHALL apply.
REQ-018 Without EFFECT_PARAM_CTRL_RAMP_EN, apply SHALL copy all shadows (including enable_delay, feedback, effect) directly and PENDING -> IDLE; RAMP is never entered.

Verification
REQ-019 Reset then no stimulus -> outputs 0,0,24,4800,0,0; wr_ready=1; busy=0.
REQ-020 Write addr1=8, commit, no sample_valid for 50 cycles -> bit_depth stays 24, busy=1; first sample_valid -> bit_depth=8 next cycle.
REQ-021 (RAMP_EN, step 4) enables=2, effect=10, commit, sample_valids -> enable_delay=1, effect 0,4,8,10, then busy=0.
REQ-022 (RAMP_EN) from effect=10 with delay enabled, write enables=0, commit -> effect 6,2,0, then enable_delay=0 one cycle later.
REQ-023 Commit during RAMP and wr_valid during busy -> ignored, wr_ready=0, shadows unchanged.
REQ-024 rst asserted mid-RAMP -> all outputs at reset values next cycle, busy=0.
